// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: two-requester round-robin controller for one cell_array,
// with a built-in FILL sequencer that writes a captured pattern to every row.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req_valid/ready    per-requester handshake (2 bits each)
//   req_we             per-requester 1 = write, 0 = read
//   req_addr           row address, requester i at [i*AW +: AW]
//   req_wdata/wmask    write data / column enables, requester i at [i*COLS +: COLS]
//   rsp_valid          one-cycle pulse per requester, read data in rsp_data
//   rsp_data           registered read data
//   fill_start/data    start a FILL sweep with the given pattern
//   fill_busy/done     sweep in progress / one-cycle completion pulse
//   arr_*              drive and read the cell_array (it is its only driver)

module sram_arb_ctrl #(
  parameter int ROWS = 64,
  parameter int COLS = 64,
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [2*AW-1:0]   req_addr,
  input  logic [2*COLS-1:0] req_wdata,
  input  logic [2*COLS-1:0] req_wmask,
  output logic [1:0]        rsp_valid,
  output logic [COLS-1:0]   rsp_data,
  input  logic              fill_start,
  input  logic [COLS-1:0]   fill_data,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [AW-1:0]     arr_row_select,
  output logic [COLS-1:0]   arr_col_write_enable,
  output logic [COLS-1:0]   arr_col_data_in,
  input  logic [COLS-1:0]   arr_col_data_out
);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  localparam logic [AW:0]   ROWS_W = (AW+1)'(ROWS);
  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

  state_t          state;
  logic [AW-1:0]   cnt;
  logic            last_grant;
  logic [COLS-1:0] pat;

  logic [1:0]      gnt;
  logic            sel;
  logic            g_we;
  logic [AW-1:0]   g_addr;
  logic [COLS-1:0] g_wdata;
  logic [COLS-1:0] g_wmask;
  logic            addr_ok;

  // Arbitration: fill_start pre-empts every grant; on a tie the
  // requester that did not win last time is chosen.
  always_comb begin
    gnt = 2'b00;
    if (!rst && state == IDLE && !fill_start) begin
      case (req_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign req_ready = gnt;
  assign sel       = gnt[1];

  always_comb begin
    g_we    = sel ? req_we[1] : req_we[0];
    g_addr  = sel ? req_addr[AW +: AW] : req_addr[0 +: AW];
    g_wdata = sel ? req_wdata[COLS +: COLS]
                  : req_wdata[0 +: COLS];
    g_wmask = sel ? req_wmask[COLS +: COLS]
                  : req_wmask[0 +: COLS];
  end

  // Out-of-range rows only exist for non-power-of-2 ROWS.
  assign addr_ok = {1'b0, g_addr} < ROWS_W;

  always_comb begin
    arr_row_select       = '0;
    arr_col_write_enable = '0;
    arr_col_data_in      = '0;
    if (!rst) begin
      case (state)
        FILL: begin
          arr_row_select       = cnt;
          arr_col_write_enable = '1;
          arr_col_data_in      = pat;
        end
        default: begin
          if (|gnt) begin
            arr_row_select = g_addr;
            if (g_we) begin
              arr_col_write_enable = addr_ok ? g_wmask : '0;
              arr_col_data_in      = g_wdata;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      pat        <= '0;
      rsp_valid  <= 2'b00;
      rsp_data   <= '0;
      fill_busy  <= 1'b0;
      fill_done  <= 1'b0;
    end else begin
      rsp_valid <= 2'b00;
      fill_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_start) begin
            pat       <= fill_data;
            cnt       <= '0;
            fill_busy <= 1'b1;
            state     <= FILL;
          end else if (|gnt) begin
            last_grant <= sel;
            if (!g_we) begin
              rsp_valid <= gnt;
              rsp_data  <= addr_ok ? arr_col_data_out : '0;
            end
          end
        end
        FILL: begin
          if (cnt == LAST_ROW) begin
            cnt       <= '0;
            fill_busy <= 1'b0;
            fill_done <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// tb_sram_arb_ctrl: directed bench for sram_arb_ctrl with a
// behavioural cell_array (sync masked write, combinational read).

module tb_sram_arb_ctrl;

  localparam int ROWS = 64;
  localparam int COLS = 64;
  localparam int AW   = 6;

  localparam logic [COLS-1:0] PAT_A5 = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [COLS-1:0] PAT_12 = 64'h1234_1234_1234_1234;
  localparam logic [COLS-1:0] PAT_5A = 64'h5A5A_5A5A_5A5A_5A5A;
  localparam logic [COLS-1:0] MSK_LO = 64'h00FF_00FF_00FF_00FF;
  localparam logic [COLS-1:0] EXP_M  = 64'hFF00_FF00_FF00_FF00;
  localparam logic [COLS-1:0] ONES   = '1;

  logic              clk;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_we;
  logic [2*AW-1:0]   req_addr;
  logic [2*COLS-1:0] req_wdata;
  logic [2*COLS-1:0] req_wmask;
  logic [1:0]        rsp_valid;
  logic [COLS-1:0]   rsp_data;
  logic              fill_start;
  logic [COLS-1:0]   fill_data;
  logic              fill_busy;
  logic              fill_done;
  logic [AW-1:0]     arr_row_select;
  logic [COLS-1:0]   arr_col_write_enable;
  logic [COLS-1:0]   arr_col_data_in;
  logic [COLS-1:0]   arr_col_data_out;

  int errors;
  int checks;

  logic [COLS-1:0] mem [ROWS];

  sram_arb_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_we               (req_we),
    .req_addr             (req_addr),
    .req_wdata            (req_wdata),
    .req_wmask            (req_wmask),
    .rsp_valid            (rsp_valid),
    .rsp_data             (rsp_data),
    .fill_start           (fill_start),
    .fill_data            (fill_data),
    .fill_busy            (fill_busy),
    .fill_done            (fill_done),
    .arr_row_select       (arr_row_select),
    .arr_col_write_enable (arr_col_write_enable),
    .arr_col_data_in      (arr_col_data_in),
    .arr_col_data_out     (arr_col_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: not reset by rst, like the real cell array.
  always @(posedge clk) begin
    mem[arr_row_select] <=
      (mem[arr_row_select] & ~arr_col_write_enable) |
      (arr_col_data_in & arr_col_write_enable);
  end
  assign arr_col_data_out = mem[arr_row_select];

  task automatic set_req(input int i, input logic we,
                         input logic [AW-1:0] a,
                         input logic [COLS-1:0] d,
                         input logic [COLS-1:0] m);
    req_valid[i]               = 1'b1;
    req_we[i]                  = we;
    req_addr[i*AW +: AW]       = a;
    req_wdata[i*COLS +: COLS]  = d;
    req_wmask[i*COLS +: COLS]  = m;
  endtask

  task automatic wr(input int i, input logic [AW-1:0] a,
                    input logic [COLS-1:0] d,
                    input logic [COLS-1:0] m);
    @(negedge clk);
    set_req(i, 1'b1, a, d, m);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
  endtask

  task automatic rd(input int i, input logic [AW-1:0] a,
                    output logic [1:0] v,
                    output logic [COLS-1:0] d);
    @(negedge clk);
    set_req(i, 1'b0, a, '0, '0);
    @(posedge clk);
    #1;
    v = rsp_valid;
    d = rsp_data;
    req_valid = 2'b00;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 2'b11;
    req_we    = 2'b11;
    req_wmask = '1;
    req_wdata = '1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got %b want 00", req_ready);
    end
    checks++;
    if (arr_col_write_enable !== '0 || arr_row_select !== '0 ||
        arr_col_data_in !== '0) begin
      errors++;
      $display("FAIL reset_arr: got we=%h row=%0d din=%h want 0",
               arr_col_write_enable, arr_row_select, arr_col_data_in);
    end
    checks++;
    if (rsp_valid !== 2'b00 || rsp_data !== '0) begin
      errors++;
      $display("FAIL reset_rsp: got v=%b d=%h want 0",
               rsp_valid, rsp_data);
    end
    checks++;
    if (fill_busy !== 1'b0 || fill_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_fill: got busy=%b done=%b want 0 0",
               fill_busy, fill_done);
    end
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_wmask = '0;
    req_wdata = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    logic [1:0] prev;
    @(negedge clk);
    set_req(0, 1'b0, 6'd1, '0, '0);
    set_req(1, 1'b0, 6'd2, '0, '0);
    prev = 2'b00;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (req_ready !== exp) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, exp);
      end
      if (k > 0) begin
        checks++;
        if (rsp_valid !== prev) begin
          errors++;
          $display("FAIL rr_rsp%0d: got %b want %b", k, rsp_valid, prev);
        end
      end
      prev = exp;
      @(negedge clk);
    end
    req_valid = 2'b00;
    checks++;
    if (rsp_valid !== 2'b10) begin
      errors++;
      $display("FAIL rr_rsp_last: got %b want 10", rsp_valid);
    end
  endtask

  task automatic test_write_read();
    logic [1:0]      v;
    logic [COLS-1:0] d;
    @(negedge clk);
    set_req(0, 1'b1, 6'd5, PAT_A5, ONES);
    #1;
    checks++;
    if (req_ready !== 2'b01 || arr_row_select !== 6'd5 ||
        arr_col_write_enable !== ONES || arr_col_data_in !== PAT_A5) begin
      errors++;
      $display("FAIL wr_drive: got rdy=%b row=%0d we=%h din=%h",
               req_ready, arr_row_select, arr_col_write_enable,
               arr_col_data_in);
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    checks++;
    if (rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL wr_no_rsp: got %b want 00", rsp_valid);
    end
    rd(0, 6'd5, v, d);
    checks++;
    if (v !== 2'b01 || d !== PAT_A5) begin
      errors++;
      $display("FAIL rd_a5: got v=%b d=%h want 01 %h", v, d, PAT_A5);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL rd_pulse: got %b want 00", rsp_valid);
    end
  endtask

  task automatic test_mask();
    logic [1:0]      v;
    logic [COLS-1:0] d;
    wr(0, 6'd3, ONES, ONES);
    wr(0, 6'd3, '0, MSK_LO);
    rd(0, 6'd3, v, d);
    checks++;
    if (v !== 2'b01 || d !== EXP_M) begin
      errors++;
      $display("FAIL mask: got v=%b d=%h want 01 %h", v, d, EXP_M);
    end
  endtask

  task automatic test_fill();
    logic [1:0]      v;
    logic [COLS-1:0] d;
    logic [AW-1:0]   rows [3];
    int blocked;
    int dones;
    bit got;
    rows = '{6'd0, 6'd31, 6'd63};
    @(negedge clk);
    fill_start = 1'b1;
    fill_data  = PAT_12;
    set_req(1, 1'b0, 6'd0, '0, '0);
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL fill_prio: got %b want 00", req_ready);
    end
    @(negedge clk);
    fill_start = 1'b0;
    fill_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    checks++;
    if (fill_busy !== 1'b1) begin
      errors++;
      $display("FAIL fill_busy: got %b want 1", fill_busy);
    end
    blocked = 1;
    dones   = 0;
    got     = 1'b0;
    for (int k = 0; k < ROWS + 8 && !got; k++) begin
      if (fill_done === 1'b1) dones++;
      if (req_ready[1] === 1'b1) got = 1'b1;
      else blocked++;
      @(negedge clk);
      #1;
    end
    req_valid = 2'b00;
    checks++;
    if (!got || blocked != ROWS + 1) begin
      errors++;
      $display("FAIL fill_block: got %0d cycles want %0d",
               blocked, ROWS + 1);
    end
    repeat (3) begin
      if (fill_done === 1'b1) dones++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (dones != 1 || fill_busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_done: got %0d pulses busy=%b want 1 0",
               dones, fill_busy);
    end
    foreach (rows[j]) begin
      rd(0, rows[j], v, d);
      checks++;
      if (v !== 2'b01 || d !== PAT_12) begin
        errors++;
        $display("FAIL fill_row%0d: got v=%b d=%h want 01 %h",
                 rows[j], v, d, PAT_12);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [1:0]      v;
    logic [COLS-1:0] d;
    int dones;
    @(negedge clk);
    fill_start = 1'b1;
    fill_data  = PAT_5A;
    @(negedge clk);
    fill_start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (arr_row_select !== 6'd10 || fill_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_row: got row=%0d busy=%b want 10 1",
               arr_row_select, fill_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (arr_row_select !== '0 || arr_col_write_enable !== '0 ||
        arr_col_data_in !== '0 || fill_busy !== 1'b0 ||
        fill_done !== 1'b0 || rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL mid_rst: got row=%0d we=%h busy=%b done=%b",
               arr_row_select, arr_col_write_enable,
               fill_busy, fill_done);
    end
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    for (int k = 0; k < ROWS + 4; k++) begin
      #1;
      if (fill_done === 1'b1 || fill_busy === 1'b1) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL mid_nodone: got %0d busy/done cycles want 0", dones);
    end
    rd(0, 6'd9, v, d);
    checks++;
    if (d !== PAT_5A) begin
      errors++;
      $display("FAIL mid_row9: got %h want %h", d, PAT_5A);
    end
    rd(0, 6'd10, v, d);
    checks++;
    if (d !== PAT_12) begin
      errors++;
      $display("FAIL mid_row10: got %h want %h", d, PAT_12);
    end
    rd(0, 6'd20, v, d);
    checks++;
    if (d !== PAT_12) begin
      errors++;
      $display("FAIL mid_row20: got %h want %h", d, PAT_12);
    end
  endtask

  task automatic test_back_to_back();
    logic [COLS-1:0] nd;
    nd = 64'h0F1E_2D3C_4B5A_6978;
    @(negedge clk);
    set_req(0, 1'b1, 6'd7, nd, ONES);
    @(negedge clk);
    req_valid = 2'b00;
    set_req(1, 1'b0, 6'd7, '0, '0);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL b2b_grant: got %b want 10", req_ready);
    end
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== nd) begin
      errors++;
      $display("FAIL b2b_raw: got v=%b d=%h want 10 %h",
               rsp_valid, rsp_data, nd);
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    req_valid  = 2'b00;
    req_we     = 2'b00;
    req_addr   = '0;
    req_wdata  = '0;
    req_wmask  = '0;
    fill_start = 1'b0;
    fill_data  = '0;
    for (int r = 0; r < ROWS; r++) mem[r] = '0;
    test_reset();
    test_round_robin();
    test_write_read();
    test_mask();
    test_fill();
    test_reset_mid_fill();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
